mips_mem_port_arbiter: RTL and testbench

- Shares one single-port 32-bit word memory between the pipelined MIPS32 core's instruction-fetch requester (IF, read-only) and data requester (D, LW/SW from the MEM stage).
- One transaction is outstanding at a time.
- D has fixed priority, bounded by an IF starvation counter.
- Sits between the core's fetch/data ports and the memory macro, which has fixed read latency.

---
 rtl/mips_mem_port_arbiter_pkg.sv | 19 +
 rtl/mips_mem_port_arbiter_starve_ctr.sv | 25 ++
 rtl/mips_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_mips_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_port_arbiter_pkg.sv
// Shared types and constants for the MIPS memory-port arbiter.
package mips_memarb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Read data returned when a WAIT times out (optional timeout build only)
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mips_mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive IF arbitration losses.
module mips_arb_starve_ctr #(
  parameter int MAX = 4,
  parameter int W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [W-1:0] cnt;

  // Clear has priority; increment holds at MAX
  always_ff @(posedge clk) begin
    if (rst)                        cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (inc && cnt != W'(MAX)) cnt <= cnt + 1'b1;
  end

  // Saturation flag forces the next IF request to win
  always_comb sat = (cnt == W'(MAX));

endmodule

// File: rtl/mips_mem_port_arbiter.sv
// Single-port memory arbiter between MIPS instruction fetch (IF) and data (D).
// D has fixed priority; IF wins after STARVE_MAX consecutive losses.
// Optional build macro MIPS_MEMARB_TIMEOUT_EN adds a WAIT timeout and the
// sticky err_timeout output.
module mips_mem_port_arbiter
  import mips_memarb_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
`ifdef MIPS_MEMARB_TIMEOUT_EN
  output logic          err_timeout,
`endif
  output logic          busy
);

  // Elaboration-time parameter range checks
  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
    $error("RD_LAT must be 1..7");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("STARVE_MAX must be 1..15");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be >= 1");
  end

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          kill_q, kill_d;

  logic          if_ack_d, d_ack_d, mem_req_d, mem_we_d, busy_d;
  logic [DW-1:0] if_rdata_d, d_rdata_d, mem_wdata_d;
  logic [AW-1:0] mem_addr_d;

  logic          st_inc, st_clr, st_sat;
  logic          fin;
  logic [DW-1:0] fin_data;

`ifdef MIPS_MEMARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_d;
`endif

  mips_arb_starve_ctr #(.MAX(STARVE_MAX), .W(4)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (st_inc),
    .clr (st_clr),
    .sat (st_sat)
  );

  // Next-state, latched request and next registered outputs
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    kill_d      = kill_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    st_inc      = 1'b0;
    st_clr      = 1'b0;
    fin         = 1'b0;
    fin_data    = mem_rdata;
`ifdef MIPS_MEMARB_TIMEOUT_EN
    wait_cnt_d  = '0;
    err_d       = err_timeout;
`endif

    // A flush during an IF transaction only suppresses the final ack
    if (owner_q == OWN_IF && state_q != IDLE && if_kill) kill_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (if_req && (st_sat || !d_req)) begin
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
          st_clr  = 1'b1;
          state_d = ISSUE;
        end else if (d_req) begin
          owner_d = OWN_D;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          st_inc  = if_req;
          state_d = ISSUE;
        end
        if (state_d == ISSUE) begin
          mem_req_d   = 1'b1;
          mem_we_d    = we_d;
          mem_addr_d  = addr_d;
          mem_wdata_d = wdata_d;
        end
      end
      ISSUE: begin
        state_d = we_q ? DONE : WAIT;
        fin     = we_q;
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = DONE;
          fin     = 1'b1;
        end
`ifdef MIPS_MEMARB_TIMEOUT_EN
        else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d  = DONE;
          fin      = 1'b1;
          fin_data = DW'(TIMEOUT_DATA);
          err_d    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Ack is registered on entry to DONE so it is visible during DONE
    if (fin) begin
      if (owner_q == OWN_D) begin
        d_ack_d = 1'b1;
        if (!we_q) d_rdata_d = fin_data;
      end else if (!(kill_q || if_kill)) begin
        if_ack_d   = 1'b1;
        if_rdata_d = fin_data;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State, latched request and all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      kill_q    <= 1'b0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      kill_q    <= kill_d;
      if_ack    <= if_ack_d;
      if_rdata  <= if_rdata_d;
      d_ack     <= d_ack_d;
      d_rdata   <= d_rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
    end
  end

`ifdef MIPS_MEMARB_TIMEOUT_EN
  // WAIT cycle counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      err_timeout <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      err_timeout <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mem_port_arbiter.sv
// Directed self-checking bench for mips_mem_port_arbiter (RD_LAT = 1).
module tb_mips_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_kill, if_ack;
  logic [9:0]  if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_ack;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_rvalid;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy;
`ifdef MIPS_MEMARB_TIMEOUT_EN
  logic        err_timeout;
`endif

  int checks   = 0;
  int failures = 0;

  // Memory model: 1-cycle read latency, reloaded on reset
  logic [31:0] mem [0:1023];
  logic        auto_rv;
  logic [31:0] auto_data;
  logic        hold_rv, man_rv;
  logic [31:0] man_data;

  function automatic logic [31:0] init_val(int a);
    return (a == 5) ? 32'h0022_2000 : 32'h1000_0000 + 32'(a);
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      auto_rv <= 1'b0;
    end else begin
      auto_rv   <= mem_req & ~mem_we;
      auto_data <= mem[mem_addr];
      if (mem_req && mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rvalid = (auto_rv & ~hold_rv) | man_rv;
  assign mem_rdata  = man_rv ? man_data : auto_data;

  mips_mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_kill    (if_kill),
    .if_ack     (if_ack),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
`ifdef MIPS_MEMARB_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .busy       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a memory strobe, return its address, step past ISSUE
  task automatic wait_grant(input string tag, output logic [9:0] a);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 20), 32'd1);
    a = mem_addr;
    tick();
  endtask

  logic [9:0] ga;

  initial begin
    rst = 1'b1; if_req = 0; if_kill = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    hold_rv = 0; man_rv = 0; man_data = 0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy",     32'(busy),    0);
    chk("rst_mem_req",  32'(mem_req), 0);
    chk("rst_acks",     32'({if_ack, d_ack}), 0);
    chk("rst_if_rdata", if_rdata,     0);
    chk("rst_d_rdata",  d_rdata,      0);

    // Isolated IF fetch of addr 5
    if_req = 1; if_addr = 10'd5;
    tick();                                      // cycle 1
    chk("if_c1_mem_req",  32'(mem_req), 1);
    chk("if_c1_mem_addr", 32'(mem_addr), 5);
    chk("if_c1_busy",     32'(busy), 1);
    tick();                                      // cycle 2
    chk("if_c2_no_ack",   32'(if_ack), 0);
    tick();                                      // cycle 3
    chk("if_c3_ack",      32'(if_ack), 1);
    chk("if_c3_rdata",    if_rdata, 32'h0022_2000);
    if_req = 0;
    tick();                                      // cycle 4
    chk("if_c4_busy",     32'(busy), 0);
    chk("if_c4_ack_pulse",32'(if_ack), 0);

    // SW 130 -> addr 121
    d_req = 1; d_we = 1; d_addr = 10'd121; d_wdata = 32'd130;
    tick();
    chk("sw_c1_mem_we",    32'({mem_req, mem_we}), 32'b11);
    chk("sw_c1_mem_wdata", mem_wdata, 130);
    tick();
    chk("sw_c2_ack",       32'(d_ack), 1);
    d_req = 0;
    tick();
    chk("sw_mem_121",      mem[121], 130);
    chk("sw_idle",         32'(busy), 0);

    // LW addr 121
    d_req = 1; d_we = 0; d_addr = 10'd121;
    tick();
    chk("lw_c1_mem_we",    32'({mem_req, mem_we}), 32'b10);
    tick();
    chk("lw_c2_no_ack",    32'(d_ack), 0);
    tick();
    chk("lw_c3_ack",       32'(d_ack), 1);
    chk("lw_c3_rdata",     d_rdata, 130);
    d_req = 0;
    tick();

    // Starvation: both request continuously; D x4, then IF, then D again
    if_req = 1; if_addr = 10'd9;
    d_req = 1; d_we = 1; d_addr = 10'd50; d_wdata = 32'h55;
    for (int g = 0; g < 6; g++) begin
      wait_grant($sformatf("starve_grant%0d_seen", g), ga);
      chk($sformatf("starve_grant%0d_addr", g), 32'(ga), (g == 4) ? 32'd9 : 32'd50);
    end
    if_req = 0; d_req = 0;
    tick(); tick(); tick();
    chk("starve_idle", 32'(busy), 0);

    // if_kill in WAIT suppresses the fetch ack
    if_req = 1; if_addr = 10'd7;
    tick();                                      // ISSUE
    tick();                                      // WAIT
    if_kill = 1; if_req = 0;
    tick();                                      // DONE
    chk("kill_no_ack", 32'(if_ack), 0);
    if_kill = 0;
    tick();
    chk("kill_idle",   32'(busy), 0);
    if_req = 1; if_addr = 10'd2;
    tick(); tick(); tick();
    chk("kill_next_ack",   32'(if_ack), 1);
    chk("kill_next_rdata", if_rdata, init_val(2));
    if_req = 0;
    tick();

    // Reset during WAIT, then a late mem_rvalid
    hold_rv = 1;
    if_req = 1; if_addr = 10'd3;
    tick(); tick(); tick();                      // ISSUE, WAIT, WAIT
    chk("rstw_busy", 32'(busy), 1);
    rst = 1; if_req = 0;
    tick();
    rst = 0; man_rv = 1; man_data = 32'h1234_5678;
    chk("rstw_outs", 32'({busy, mem_req, if_ack, d_ack}), 0);
    chk("rstw_rdata", if_rdata, 0);
    tick();
    chk("rstw_late_rv_ignored", 32'({busy, if_ack, d_ack}), 0);
    chk("rstw_late_rdata",      if_rdata, 0);
    man_rv = 0; hold_rv = 0;

    // Next request completes normally; if_kill in IDLE has no effect
    if_req = 1; if_addr = 10'd4; if_kill = 1;
    tick();
    if_kill = 0;
    tick(); tick();
    chk("post_rst_ack",   32'(if_ack), 1);
    chk("post_rst_rdata", if_rdata, init_val(4));
    if_req = 0;
    tick();

`ifdef MIPS_MEMARB_TIMEOUT_EN
    begin
      int n = 0;
      hold_rv = 1;
      if_req = 1; if_addr = 10'd6;
      tick();
      while (!if_ack && n < 40) begin
        tick();
        n++;
      end
      chk("to_ack_cycle", 32'(n + 1), 18);
      chk("to_rdata",     if_rdata, 32'hDEAD_BEEF);
      chk("to_err",       32'(err_timeout), 1);
      if_req = 0; hold_rv = 0;
      tick(); tick();
      chk("to_err_sticky", 32'(err_timeout), 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
